// File: rtl/mux_cfg_pkg.sv
// Shared types and helpers for the configurable routing multiplexer.
// Select width and status encoding are common to the top and its mux-tree core.
package mux_cfg_pkg;

  localparam logic CONST_DEFAULT = 1'b1;

  typedef struct packed {
    logic valid;
    logic err;
  } cfg_status_t;

  // One extra code beyond NUM_IN so an all-ones select is always out of range.
  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mux_tree_cfg_core.sv
// Combinational NUM_IN-to-1 binary mux tree with a buffered output.
// Leaves beyond NUM_IN are tied to CONST_VAL so out-of-range selects are benign.
module mux_tree_cfg_core #(
  parameter int   NUM_IN    = 41,
  parameter int   SEL_W     = 6,
  parameter logic CONST_VAL = 1'b1
) (
  input  logic [NUM_IN-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  localparam int LEAVES = 1 << SEL_W;

  // Heap-ordered node array: node i has children 2i and 2i+1, leaves start at LEAVES.
  logic [2*LEAVES-1:1] node;

  genvar gi, gj;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < NUM_IN) begin : g_used
        assign node[LEAVES+gi] = in[gi];
      end else begin : g_pad
        assign node[LEAVES+gi] = CONST_VAL;
      end
    end

    // Depth gi is steered by select bit SEL_W-1-gi, so the root decodes the MSB.
    for (gi = 0; gi < SEL_W; gi++) begin : g_level
      for (gj = 0; gj < (1 << gi); gj++) begin : g_mux2
        assign node[(1<<gi)+gj] = sel[SEL_W-1-gi] ? node[2*((1<<gi)+gj)+1]
                                                  : node[2*((1<<gi)+gj)];
      end
    end
  endgenerate

  assign out = node[1];

endmodule

// File: rtl/mux_tree_cfg_chain.sv
// Routing mux with its own serial config segment: shadow shift register,
// validated commit into the active select, and a force-to-constant gate.
module mux_tree_cfg_chain
  import mux_cfg_pkg::*;
#(
  parameter int   NUM_IN    = 41,
  parameter logic CONST_VAL = CONST_DEFAULT,
  localparam int  SEL_W     = sel_width(NUM_IN)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              cfg_commit,
  input  logic [NUM_IN-1:0] in,
  output logic              out,
  output logic              ccff_tail,
  output logic              cfg_valid,
  output logic              cfg_err,
  output logic [SEL_W-1:0]  sel_q
);

  localparam int               CNT_W    = $clog2(SEL_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SEL_W);
  localparam logic [SEL_W-1:0] SEL_LIM  = SEL_W'(NUM_IN);

  logic [SEL_W-1:0] shadow_q;
  logic [SEL_W-1:0] active_q;
  logic [CNT_W-1:0] cnt_q;
  cfg_status_t      status_q;
  logic             tree_out;

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      shadow_q <= '0;
      active_q <= '1;
      cnt_q    <= '0;
      status_q <= '0;
    end else begin
      if (ccff_en) begin
        shadow_q <= {shadow_q[SEL_W-2:0], ccff_head};
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
      end
      // A commit only loads when a full word is present and the chain is idle.
      if (cfg_commit) begin
        cnt_q <= '0;
        if (!ccff_en && cnt_q == CNT_FULL) begin
          active_q       <= shadow_q;
          status_q.valid <= 1'b1;
          status_q.err   <= (shadow_q >= SEL_LIM);
        end else begin
          status_q.err <= 1'b1;
        end
      end
    end
  end

  mux_tree_cfg_core #(
    .NUM_IN   (NUM_IN),
    .SEL_W    (SEL_W),
    .CONST_VAL(CONST_VAL)
  ) u_core (
    .in (in),
    .sel(active_q),
    .out(tree_out)
  );

  assign out       = status_q.valid ? tree_out : CONST_VAL;
  assign ccff_tail = shadow_q[SEL_W-1];
  assign cfg_valid = status_q.valid;
  assign cfg_err   = status_q.err;
  assign sel_q     = active_q;

endmodule

// File: tb/tb_mux_tree_cfg_chain.sv
// Directed bench for mux_tree_cfg_chain: two chained NUM_IN=41 instances,
// the first driven from the bench, the second fed by the first's ccff_tail.
module tb_mux_tree_cfg_chain;

  logic        prog_clk = 1'b0;
  logic        prog_rst_n;
  logic        ccff_head;
  logic        ccff_en;
  logic        cfg_commit;
  logic [40:0] din;
  logic        out_a, tail_a, valid_a, err_a;
  logic        out_b, tail_b, valid_b, err_b;
  logic [5:0]  sel_a, sel_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 prog_clk = ~prog_clk;

  mux_tree_cfg_chain #(.NUM_IN(41), .CONST_VAL(1'b1)) u_dut (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .ccff_head (ccff_head),
    .ccff_en   (ccff_en),
    .cfg_commit(cfg_commit),
    .in        (din),
    .out       (out_a),
    .ccff_tail (tail_a),
    .cfg_valid (valid_a),
    .cfg_err   (err_a),
    .sel_q     (sel_a)
  );

  mux_tree_cfg_chain #(.NUM_IN(41), .CONST_VAL(1'b1)) u_dut2 (
    .prog_clk  (prog_clk),
    .prog_rst_n(prog_rst_n),
    .ccff_head (tail_a),
    .ccff_en   (ccff_en),
    .cfg_commit(cfg_commit),
    .in        (din),
    .out       (out_b),
    .ccff_tail (tail_b),
    .cfg_valid (valid_b),
    .cfg_err   (err_b),
    .sel_q     (sel_b)
  );

  // Drive n bits of v MSB-first, one per cycle, then drop the enable.
  task automatic shift_word(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge prog_clk);
      ccff_head = v[i];
      ccff_en   = 1'b1;
    end
    @(negedge prog_clk);
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge prog_clk);
    cfg_commit = 1'b1;
    @(negedge prog_clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    prog_rst_n = 1'b0;
    din        = '1;
    repeat (3) @(negedge prog_clk);
    tests_run++; if (out_a !== 1'b1) begin tests_failed++; $display("FAIL reset_out: got %b expected 1", out_a); end
    tests_run++; if (sel_a !== 6'h3F) begin tests_failed++; $display("FAIL reset_sel: got %h expected 3f", sel_a); end
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err_a); end
    tests_run++; if (tail_a !== 1'b0) begin tests_failed++; $display("FAIL reset_tail: got %b expected 0", tail_a); end
    $display("[TB] reset: out=%b sel_q=%h valid=%b err=%b tail=%b", out_a, sel_a, valid_a, err_a, tail_a);
    #1 prog_rst_n = 1'b1;
  endtask

  task automatic test_select17();
    shift_word(16'd17, 6);
    do_commit();
    tests_run++; if (sel_a !== 6'd17) begin tests_failed++; $display("FAIL sel17_sel: got %0d expected 17", sel_a); end
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL sel17_valid: got %b expected 1", valid_a); end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL sel17_err: got %b expected 0", err_a); end
    din = '1; din[17] = 1'b0; #1;
    tests_run++; if (out_a !== 1'b0) begin tests_failed++; $display("FAIL sel17_out_lo: got %b expected 0", out_a); end
    din = '0; din[17] = 1'b1; #1;
    tests_run++; if (out_a !== 1'b1) begin tests_failed++; $display("FAIL sel17_out_hi: got %b expected 1", out_a); end
    $display("[TB] select17: sel_q=%0d valid=%b err=%b out=%b", sel_a, valid_a, err_a, out_a);
  endtask

  task automatic test_short_shift();
    shift_word(16'h000A, 4);
    do_commit();
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL short_err: got %b expected 1", err_a); end
    tests_run++; if (sel_a !== 6'd17) begin tests_failed++; $display("FAIL short_sel: got %0d expected 17", sel_a); end
    din = '1; din[17] = 1'b0; #1;
    tests_run++; if (out_a !== 1'b0) begin tests_failed++; $display("FAIL short_out: got %b expected 0", out_a); end
    $display("[TB] short_shift: sel_q=%0d err=%b out=%b", sel_a, err_a, out_a);
  endtask

  task automatic test_back_to_back();
    shift_word(16'd5, 6);
    do_commit();
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_err: got %b expected 0", err_a); end
    do_commit();
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_err: got %b expected 1", err_a); end
    tests_run++; if (sel_a !== 6'd5) begin tests_failed++; $display("FAIL b2b_sel: got %0d expected 5", sel_a); end
    din = '0; din[5] = 1'b1; #1;
    tests_run++; if (out_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_out: got %b expected 1", out_a); end
    $display("[TB] back_to_back: sel_q=%0d err=%b out=%b", sel_a, err_a, out_a);
    // Full 6-bit shift of 9 with the commit on the last shift cycle: must be rejected.
    for (int i = 5; i >= 0; i--) begin
      @(negedge prog_clk);
      ccff_head  = 1'(6'd9 >> i);
      ccff_en    = 1'b1;
      cfg_commit = (i == 0);
    end
    @(negedge prog_clk);
    ccff_en = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b0;
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL shift_commit_err: got %b expected 1", err_a); end
    tests_run++; if (sel_a !== 6'd5) begin tests_failed++; $display("FAIL shift_commit_sel: got %0d expected 5", sel_a); end
    $display("[TB] commit_during_shift: sel_q=%0d err=%b", sel_a, err_a);
  endtask

  task automatic test_out_of_range();
    shift_word(16'd45, 6);
    do_commit();
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL oor_err: got %b expected 1", err_a); end
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL oor_valid: got %b expected 1", valid_a); end
    tests_run++; if (sel_a !== 6'd45) begin tests_failed++; $display("FAIL oor_sel: got %0d expected 45", sel_a); end
    din = '0; #1;
    tests_run++; if (out_a !== 1'b1) begin tests_failed++; $display("FAIL oor_out_zero_in: got %b expected 1", out_a); end
    $display("[TB] out_of_range: sel_q=%0d valid=%b err=%b out=%b", sel_a, valid_a, err_a, out_a);
  endtask

  task automatic test_oversize_shift();
    // 8 bits 11_000111: only the last six (7) are kept.
    shift_word(16'h00C7, 8);
    do_commit();
    tests_run++; if (sel_a !== 6'd7) begin tests_failed++; $display("FAIL oversize_sel: got %0d expected 7", sel_a); end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL oversize_err: got %b expected 0", err_a); end
    din = '1; din[7] = 1'b0; #1;
    tests_run++; if (out_a !== 1'b0) begin tests_failed++; $display("FAIL oversize_out: got %b expected 0", out_a); end
    $display("[TB] oversize_shift: sel_q=%0d err=%b out=%b", sel_a, err_a, out_a);
  endtask

  task automatic test_chain();
    logic [11:0] stream;
    logic        exp_tail;
    stream = {6'd3, 6'd40};
    @(negedge prog_clk);
    prog_rst_n = 1'b0;
    @(negedge prog_clk);
    #1 prog_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge prog_clk);
      ccff_head = stream[11-i];
      ccff_en   = 1'b1;
      @(negedge prog_clk);
      ccff_en   = 1'b0;
      exp_tail  = (i >= 5) ? stream[11-(i-5)] : 1'b0;
      tests_run++; if (tail_a !== exp_tail) begin tests_failed++; $display("FAIL chain_tail_%0d: got %b expected %b", i, tail_a, exp_tail); end
      $display("[TB] chain shift %0d: head=%b tail_a=%b", i, stream[11-i], tail_a);
    end
    do_commit();
    tests_run++; if (sel_a !== 6'd40) begin tests_failed++; $display("FAIL chain_sel_a: got %0d expected 40", sel_a); end
    tests_run++; if (sel_b !== 6'd3) begin tests_failed++; $display("FAIL chain_sel_b: got %0d expected 3", sel_b); end
    tests_run++; if (valid_b !== 1'b1 || err_b !== 1'b0) begin tests_failed++; $display("FAIL chain_status_b: got valid=%b err=%b expected valid=1 err=0", valid_b, err_b); end
    tests_run++; if (tail_b !== 1'b0) begin tests_failed++; $display("FAIL chain_tail_b: got %b expected 0", tail_b); end
    din = '0; din[3] = 1'b1; #1;
    tests_run++; if (out_b !== 1'b1 || out_a !== 1'b0) begin tests_failed++; $display("FAIL chain_out: got a=%b b=%b expected a=0 b=1", out_a, out_b); end
    $display("[TB] chain: sel_a=%0d sel_b=%0d out_a=%b out_b=%b", sel_a, sel_b, out_a, out_b);
  endtask

  task automatic test_reset_mid_shift();
    logic [5:0] v;
    v = 6'b101101;
    for (int i = 5; i >= 3; i--) begin
      @(negedge prog_clk);
      ccff_head = v[i];
      ccff_en   = 1'b1;
    end
    #2 prog_rst_n = 1'b0;
    #1;
    tests_run++; if (sel_a !== 6'h3F || valid_a !== 1'b0 || err_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_state: got sel=%h valid=%b err=%b expected 3f 0 0", sel_a, valid_a, err_a); end
    tests_run++; if (tail_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_tail: got %b expected 0", tail_a); end
    ccff_en = 1'b0;
    @(negedge prog_clk);
    #1 prog_rst_n = 1'b1;
    // A 4-bit load must still count as short: the pre-reset bit count is gone.
    shift_word(16'd0, 4);
    do_commit();
    tests_run++; if (err_a !== 1'b1 || valid_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_residue: got err=%b valid=%b expected err=1 valid=0", err_a, valid_a); end
    shift_word(16'd0, 6);
    do_commit();
    tests_run++; if (sel_a !== 6'd0 || err_a !== 1'b0 || valid_a !== 1'b1) begin tests_failed++; $display("FAIL midrst_reload: got sel=%0d err=%b valid=%b expected 0 0 1", sel_a, err_a, valid_a); end
    din = '1; din[0] = 1'b0; #1;
    tests_run++; if (out_a !== 1'b0) begin tests_failed++; $display("FAIL midrst_out: got %b expected 0", out_a); end
    $display("[TB] reset_mid_shift: sel_q=%0d valid=%b err=%b out=%b", sel_a, valid_a, err_a, out_a);
  endtask

  initial begin
    prog_rst_n = 1'b0;
    ccff_head  = 1'b0;
    ccff_en    = 1'b0;
    cfg_commit = 1'b0;
    din        = '1;
    test_reset();
    test_select17();
    test_short_shift();
    test_back_to_back();
    test_out_of_range();
    test_oversize_shift();
    test_chain();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
